multiword_add_seq: RTL
======================

Name: multiword_add_seq

Overview:
Sequencer directly upstream of prefix_adder_16bit: accepts WORDS*16-bit add/subtract operations over a valid/ready handshake and feeds the 16-bit adder one word per cycle, least-significant word first.
- Chains adder Cout back to Cin between words.
- Assembles the wide sum and produces carry, signed-overflow and zero flags.
- Gives the datapath wide arithmetic while reusing one 16-bit prefix adder instance.

Parameters:
- WORDS, default 4: number of 16-bit words per operand (operand width 16*WORDS). Legal range 1..16.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  sequencer can accept an operation.
- a  input  16*WORDS  operand A.
- b  input  16*WORDS  operand B.
- cin  input  1  carry-in for add; ignored when op_sub=1.
- op_sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  16*WORDS  result.
- cout  output  1  final carry out. For subtract, 1 = no borrow.
- ovf  output  1  two's-complement overflow of the full-width operation.
- zero  output  1  sum == 0.

Behaviour:
- Internal: one prefix_adder_16bit instance; registers a_reg, b_reg, sum_reg, carry, and idx (word index, width clog2(WORDS) min 1); FSM states IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, idx=0, carry=0, sum/cout/ovf/zero=0, out_valid=0. in_ready=1 once rst deasserts. A partially computed operation is discarded and never reported.
- in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE), registered.
- IDLE, on in_valid && in_ready:
  - a_reg<=a; b_reg<= op_sub ? ~b : b; carry<= op_sub ? 1 : cin; idx<=0; go to RUN.
- RUN, every cycle:
  - Adder sees A=a_reg word[idx], B=b_reg word[idx], Cin=carry.
  - sum_reg word[idx]<=S; carry<=Cout.
  - If idx==WORDS-1: go to DONE and register flags from the final word. Else idx<=idx+1.
- Flags, computed on the last RUN cycle:
  - cout = adder Cout.
  - ovf = (a_msb == b_eff_msb) && (S msb != a_msb), where b_eff is the inverted B for subtract.
  - zero = (full new sum == 0), including the word being written this cycle.
- Latency: handshake accepted at edge k → out_valid high after edge k+WORDS. WORDS=1 gives a single RUN cycle.
- DONE: sum, cout, ovf, zero held stable while out_valid=1 && out_ready=0. On out_ready=1 go to IDLE; out_valid drops next cycle.
- Inputs a, b, cin, op_sub and in_valid are ignored outside the accepting cycle. Changes during RUN/DONE must not disturb the result.
- Throughput without the option: one operation per WORDS+2 cycles at best.

Optional Feature:
- Macro: ADDSEQ_B2B_EN.
- Defined:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - A simultaneous result handoff and new request in DONE goes directly to RUN with the new operands latched; no IDLE bubble.
  - out_valid deasserts for that cycle.
  - Throughput: one operation per WORDS+1 cycles.
- Undefined: in_ready only in IDLE, exactly as in Behaviour.

Test Plan:
- WORDS=4, add, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → sum=0, cout=1, zero=1, ovf=0; out_valid rises exactly 4 cycles after accept.
- Add, A=0x0000_0000_0000_FFFF, B=0, cin=1 → sum=0x0000_0000_0001_0000, cout=0 (carry chained across words).
- Sub, A=5, B=7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Separately, add A=0x7FFF_FFFF_FFFF_FFFF, B=1 → sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling a/b/in_valid → sum and flags unchanged, in_ready=0, no new op accepted; result released on first out_ready=1.
- Assert rst when idx==2 → out_valid=0 immediately, in_ready=1 after release, no stale result ever appears. Then 0x1+0x2 completes as sum=0x3.
- ADDSEQ_B2B_EN defined: two back-to-back ops (0x3+0x3 cin=1, then 0xF0+0xF0) with out_ready=1 → results 0x7 then 0x1E0, second out_valid exactly 5 cycles after the first.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract sequencer: feeds one 16-bit prefix adder a word per cycle, LSW first.
// Optional back-to-back issue from DONE is enabled by defining ADDSEQ_B2B_EN.

module prefix_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  // Kogge-Stone group generate over 17 positions; position 0 carries cin with propagate 0.
  function automatic logic [16:0] prefix_carries(input logic [16:0] g_in, input logic [16:0] p_in);
    logic [16:0] g;
    logic [16:0] p;
    g = g_in;
    p = p_in;
    for (int l = 0; l < 5; l++) begin
      g = g | (p & (g << (1 << l)));
      p = p & (p << (1 << l));
    end
    return g;
  endfunction

  logic [16:0] gen_s;
  logic [16:0] prop_s;
  logic [16:0] car_s;

  assign gen_s  = {a & b, cin};
  assign prop_s = {a ^ b, 1'b0};
  assign car_s  = prefix_carries(gen_s, prop_s);
  assign s      = prop_s[16:1] ^ car_s[15:0];
  assign cout   = car_s[16];

endmodule

module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] a,
  input  logic [16*WORDS-1:0] b,
  input  logic                cin,
  input  logic                op_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                zero
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    sum_r;
  logic            carry_r;
  logic [IW-1:0]   idx_r;

  logic [15:0]     word_a_s;
  logic [15:0]     word_b_s;
  logic [15:0]     word_sum_s;
  logic            word_co_s;
  logic [W-1:0]    new_sum_s;
  logic            last_s;
  logic            accept_s;

  prefix_adder_16bit u_adder (
    .a    (word_a_s),
    .b    (word_b_s),
    .cin  (carry_r),
    .s    (word_sum_s),
    .cout (word_co_s)
  );

  assign word_a_s = a_r[{idx_r, 4'b0000} +: 16];
  assign word_b_s = b_r[{idx_r, 4'b0000} +: 16];
  assign last_s   = (idx_r == IW'(WORDS - 1));
  assign accept_s = in_valid && in_ready;
  assign sum      = sum_r;

`ifdef ADDSEQ_B2B_EN
  assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
`else
  assign in_ready = (state_r == IDLE);
`endif

  // Sum with the current word merged in, so the zero flag sees the complete result.
  always_comb begin
    new_sum_s = sum_r;
    new_sum_s[{idx_r, 4'b0000} +: 16] = word_sum_s;
  end

  // Sequencer state, operand capture, word-serial accumulation and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= {W{1'b0}};
      b_r       <= {W{1'b0}};
      sum_r     <= {W{1'b0}};
      carry_r   <= 1'b0;
      idx_r     <= {IW{1'b0}};
      out_valid <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= op_sub ? ~b : b;
            carry_r <= op_sub ? 1'b1 : cin;
            idx_r   <= {IW{1'b0}};
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          sum_r   <= new_sum_s;
          carry_r <= word_co_s;
          if (last_s) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            cout      <= word_co_s;
            // b_r already holds the effective (inverted for subtract) operand.
            ovf       <= (a_r[W-1] == b_r[W-1]) && (word_sum_s[15] != a_r[W-1]);
            zero      <= (new_sum_s == {W{1'b0}});
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
`ifdef ADDSEQ_B2B_EN
            if (in_valid) begin
              a_r     <= a;
              b_r     <= op_sub ? ~b : b;
              carry_r <= op_sub ? 1'b1 : cin;
              idx_r   <= {IW{1'b0}};
              state_r <= RUN;
            end else begin
              state_r <= IDLE;
            end
`else
            state_r <= IDLE;
`endif
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
